// File: rtl/symm_orth_pkg.sv
// Shared definitions for the symmetric orthogonalization control path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package symm_orth_pkg;

    // Sequencer states; one full iteration walks MUL1 .. CHK once.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_MUL1  = 4'd1,
        ST_WAIT1 = 4'd2,
        ST_MUL2  = 4'd3,
        ST_WAIT2 = 4'd4,
        ST_SUB   = 4'd5,
        ST_WLD   = 4'd6,
        ST_CHK   = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    // Multiplier operand select codes, shared with the multiplier input mux.
    localparam logic SEL_WWT  = 1'b0;  // W * W^T
    localparam logic SEL_WWTW = 1'b1;  // (W * W^T) * W

    // Every state other than IDLE counts as an active run.
    function automatic logic is_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/symm_lat_cnt.sv
// Down-counter that times the multiplier latency between issue and result.
// Latency: load takes effect on the next edge; zero flag is combinational from the count.
// Backpressure: none; load has priority over decrement, decrement stops at zero.
module symm_lat_cnt #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on issue, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/symm_orth_seq.sv
// Control sequencer for iterative symmetric orthogonalization W <- f(W, W*W^T*W).
// Latency: one iteration is 2*MUL_LAT+5 cycles; all outputs are registered from next state.
// Backpressure: none; start only accepted in IDLE, abort returns to IDLE on the next edge.
module symm_orth_seq
    import symm_orth_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk_seq,
    input  logic             rst_seq,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] iter_lim,
    input  logic             conv,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             en_mul,
    output logic             mul_sel,
    output logic             en_sub,
    output logic             en_wld,
    output logic [CNT_W-1:0] iter
);

    // The wait counter is loaded in the issue state, so the WAIT state lasts
    // MUL_LAT cycles when it starts at MUL_LAT-1 and leaves on zero.
    localparam logic [3:0] LAT_LOAD = 4'(MUL_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W:0]   iter_inc;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             en_mul_q, en_mul_d;
    logic             mul_sel_q, mul_sel_d;
    logic             en_sub_q, en_sub_d;
    logic             en_wld_q, en_wld_d;
    logic             cnt_load, cnt_dec, cnt_zero;

    symm_lat_cnt #(
        .W(4)
    ) u_lat_cnt (
        .clk_i      (clk_seq),
        .rst_i      (rst_seq),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next state, iteration bookkeeping and registered-output precomputation.
    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        lim_d     = lim_q;
        timeout_d = timeout_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        // One bit wider so the limit compare can never alias on wrap.
        iter_inc  = {1'b0, iter_q} + {{CNT_W{1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_MUL1;
                    iter_d    = '0;
                    timeout_d = 1'b0;
                    // A zero limit still runs one iteration.
                    lim_d     = (iter_lim == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : iter_lim;
                end
            end
            ST_MUL1: begin
                state_d  = ST_WAIT1;
                cnt_load = 1'b1;
            end
            ST_WAIT1: begin
                if (cnt_zero) state_d = ST_MUL2;
                else          cnt_dec = 1'b1;
            end
            ST_MUL2: begin
                state_d  = ST_WAIT2;
                cnt_load = 1'b1;
            end
            ST_WAIT2: begin
                if (cnt_zero) state_d = ST_SUB;
                else          cnt_dec = 1'b1;
            end
            ST_SUB:  state_d = ST_WLD;
            ST_WLD:  state_d = ST_CHK;
            ST_CHK: begin
                // Saturate rather than wrap.
                iter_d = (&iter_q) ? iter_q : iter_inc[CNT_W-1:0];
                if (conv) begin
                    state_d = ST_DONE;
                end else if (iter_inc == {1'b0, lim_q}) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    state_d = ST_MUL1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything in an active run, including the CHK decision.
        if (abort && is_busy(state_q)) begin
            state_d   = ST_IDLE;
            iter_d    = iter_q;
            timeout_d = timeout_q;
            cnt_load  = 1'b0;
            cnt_dec   = 1'b0;
        end

        busy_d    = is_busy(state_d);
        done_d    = (state_d == ST_DONE);
        en_mul_d  = (state_d == ST_MUL1) || (state_d == ST_MUL2);
        en_sub_d  = (state_d == ST_SUB);
        en_wld_d  = (state_d == ST_WLD);
        mul_sel_d = mul_sel_q;
        if (state_d == ST_MUL1) mul_sel_d = SEL_WWT;
        if (state_d == ST_MUL2) mul_sel_d = SEL_WWTW;
    end

    // State, bookkeeping and output registers; reset wins over all inputs.
    always_ff @(posedge clk_seq) begin
        if (rst_seq) begin
            state_q   <= ST_IDLE;
            iter_q    <= '0;
            lim_q     <= '0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_mul_q  <= 1'b0;
            mul_sel_q <= 1'b0;
            en_sub_q  <= 1'b0;
            en_wld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            lim_q     <= lim_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_mul_q  <= en_mul_d;
            mul_sel_q <= mul_sel_d;
            en_sub_q  <= en_sub_d;
            en_wld_q  <= en_wld_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign en_mul  = en_mul_q;
    assign mul_sel = mul_sel_q;
    assign en_sub  = en_sub_q;
    assign en_wld  = en_wld_q;
    assign iter    = iter_q;

endmodule

// File: tb/tb_symm_orth_seq.sv
// Directed bench for symm_orth_seq: scoreboarded runs plus a strobe-ordering monitor.
// Latency: done expected iterations*(2*MUL_LAT+5)+1 negedges after start is driven.
// Backpressure: n/a.
module tb_symm_orth_seq;

    localparam int L     = 4;
    localparam int CW    = 8;
    localparam int ITCYC = 2 * L + 5;

    logic          clk_seq = 1'b0;
    logic          rst_seq = 1'b1;
    logic          start   = 1'b0;
    logic          abort   = 1'b0;
    logic [CW-1:0] iter_lim = '0;
    logic          conv    = 1'b0;
    logic          busy, done, timeout, en_mul, mul_sel, en_sub, en_wld;
    logic [CW-1:0] iter;

    int n_asrt = 0;
    int n_fail = 0;

    int mcyc   = 0;
    int t_sel0 = -100;
    int t_sel1 = -100;
    int t_sub  = -100;
    int n_mul  = 0;
    int n_sub  = 0;
    int n_wld  = 0;
    int n_done = 0;

    typedef struct {
        int            lat;
        logic [CW-1:0] it;
        logic          to;
    } exp_t;
    exp_t sb[$];

    symm_orth_seq #(.MUL_LAT(L), .CNT_W(CW)) dut (
        .clk_seq  (clk_seq),
        .rst_seq  (rst_seq),
        .start    (start),
        .abort    (abort),
        .iter_lim (iter_lim),
        .conv     (conv),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .en_mul   (en_mul),
        .mul_sel  (mul_sel),
        .en_sub   (en_sub),
        .en_wld   (en_wld),
        .iter     (iter)
    );

    always #5 clk_seq = ~clk_seq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Strobe monitor: exclusivity and spacing of the per-iteration strobe sequence.
    always @(negedge clk_seq) begin
        mcyc++;
        if (en_mul || en_sub || en_wld)
            chk("strobe_excl", 32'(int'(en_mul) + int'(en_sub) + int'(en_wld)), 1);
        if (en_mul) n_mul++;
        if (en_sub) n_sub++;
        if (en_wld) n_wld++;
        if (done)   n_done++;
        if (en_mul && !mul_sel) t_sel0 = mcyc;
        if (en_mul && mul_sel) begin
            chk("mul2_gap", 32'(mcyc - t_sel0), L + 1);
            t_sel1 = mcyc;
        end
        if (en_sub) begin
            chk("sub_gap", 32'(mcyc - t_sel1), L + 1);
            chk("sel_hold", 32'(mul_sel), 1);
            t_sub = mcyc;
        end
        if (en_wld) chk("wld_gap", 32'(mcyc - t_sub), 1);
    end

    // One complete run expected to end in done; conv rises after conv_after negedges.
    task automatic run(input logic [CW-1:0] lim, input int conv_after, input int iters,
                       input logic to_exp, input bit poke);
        exp_t e, got;
        bit   seen;
        e.lat = iters * ITCYC + 1;
        e.it  = CW'(iters);
        e.to  = to_exp;
        sb.push_back(e);
        @(negedge clk_seq);
        iter_lim = lim;
        conv     = (conv_after == 0);
        start    = 1'b1;
        seen     = 1'b0;
        for (int n = 1; n <= 5000 && !seen; n++) begin
            @(negedge clk_seq);
            start = 1'b0;
            if (n == conv_after) conv = 1'b1;
            if (done) begin
                seen = 1'b1;
                got  = sb.pop_front();
                chk("done_latency", 32'(n), 32'(got.lat));
                chk("iter_at_done", 32'(iter), 32'(got.it));
                chk("timeout_at_done", 32'(timeout), 32'(got.to));
                chk("busy_in_done", 32'(busy), 1);
            end
        end
        chk("done_seen", 32'(seen), 1);
        if (!seen) void'(sb.pop_front());
        if (poke) start = 1'b1;
        @(negedge clk_seq);
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_after_done", 32'(busy), 0);
        conv = 1'b0;
    endtask

    initial begin
        int snap_mul, snap_sub, snap_wld, snap_done;

        // Reset state
        repeat (3) @(negedge clk_seq);
        rst_seq = 1'b0;
        @(negedge clk_seq);
        chk("reset_outputs", 32'({busy, done, timeout, en_mul, mul_sel, en_sub, en_wld, iter}), 0);

        // Convergence at first CHK
        run(8'd5, 0, 1, 1'b0, 1'b0);

        // Timeout after three iterations; start in DONE must be ignored
        run(8'd3, -1, 3, 1'b1, 1'b1);
        repeat (5) @(negedge clk_seq);
        chk("timeout_sticky", 32'(timeout), 1);
        chk("iter_kept", 32'(iter), 3);
        chk("no_restart", 32'(busy), 0);

        // Zero limit behaves as one iteration
        run(8'd0, -1, 1, 1'b1, 1'b0);
        run(8'd0, 0, 1, 1'b0, 1'b0);

        // Convergence on second iteration
        run(8'd10, 14, 2, 1'b0, 1'b0);

        // Abort in WAIT2 of iteration 2
        @(negedge clk_seq);
        iter_lim = 8'd5;
        conv     = 1'b0;
        start    = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            @(negedge clk_seq);
            start = 1'b0;
        end
        snap_done = n_done;
        abort = 1'b1;
        @(negedge clk_seq);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_iter", 32'(iter), 1);
        chk("abort_timeout", 32'(timeout), 0);
        snap_mul = n_mul;
        snap_sub = n_sub;
        snap_wld = n_wld;
        repeat (30) @(negedge clk_seq);
        chk("abort_no_done", 32'(n_done - snap_done), 0);
        chk("abort_no_strobes", 32'((n_mul - snap_mul) + (n_sub - snap_sub) + (n_wld - snap_wld)), 0);

        // Abort wins over the limit decision in CHK
        @(negedge clk_seq);
        iter_lim = 8'd1;
        start    = 1'b1;
        snap_done = n_done;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk_seq);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk_seq);
        abort = 1'b0;
        repeat (3) @(negedge clk_seq);
        chk("abort_chk_no_done", 32'(n_done - snap_done), 0);
        chk("abort_chk_timeout", 32'(timeout), 0);
        chk("abort_chk_busy", 32'(busy), 0);

        // Reset in SUB
        @(negedge clk_seq);
        iter_lim = 8'd5;
        start    = 1'b1;
        snap_wld = n_wld;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk_seq);
            start = 1'b0;
        end
        chk("in_sub", 32'(en_sub), 1);
        rst_seq = 1'b1;
        @(negedge clk_seq);
        rst_seq = 1'b0;
        chk("reset_midrun_outputs", 32'({busy, done, timeout, en_mul, mul_sel, en_sub, en_wld, iter}), 0);
        repeat (5) @(negedge clk_seq);
        chk("reset_no_wld", 32'(n_wld - snap_wld), 0);
        run(8'd5, 0, 1, 1'b0, 1'b0);

        // Reset beats start in the same cycle
        @(negedge clk_seq);
        rst_seq = 1'b1;
        start   = 1'b1;
        @(negedge clk_seq);
        rst_seq = 1'b0;
        start   = 1'b0;
        chk("reset_over_start", 32'(busy), 0);

        // Full-range limit reaches all-ones
        run(8'hFF, -1, 255, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
